ifmap_skew_feeder: RTL

- Downstream of the conv data mover's mem0 path (mem0_q0_o / mem0_q0_vaild).
- Takes one PE_SIZE-lane ifmap row vector per cycle and applies the diagonal skew the systolic array needs: lane k is delayed k cycles relative to lane 0.
- Runs a bounded transfer of num_rows_i vectors and drains the skew pipeline.
- Signals done so the top-level sequencer can start the next tile.

---
 rtl/conv_sa_pkg.sv | 19 +
 rtl/skew_delay_line.sv | 37 +++
 rtl/ifmap_skew_feeder.sv | 98 +++++++++
 3 files changed

// File: rtl/conv_sa_pkg.sv
// Shared constants and FSM encoding for the conv data mover / systolic array boundary.
package conv_sa_pkg;

    localparam int DEF_PE_SIZE       = 16;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_ROW_CNT_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } sa_state_e;

    // LSB of lane k inside a packed row vector of width-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage {valid, data} shift register; shifts every cycle, no stall.
// Latency DEPTH cycles; no backpressure.
module skew_delay_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  tap_valid,
    output logic [DATA_WIDTH-1:0] tap_data
);

    logic [DEPTH-1:0]      vld;
    logic [DATA_WIDTH-1:0] dat [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= push_valid;
            dat[0] <= push_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign tap_valid = vld[DEPTH-1];
    assign tap_data  = dat[DEPTH-1];

endmodule

// File: rtl/ifmap_skew_feeder.sv
// Feeds a bounded run of ifmap rows into the systolic array with lane k delayed k cycles.
// Lane k latency k+1 cycles; accepts one row per cycle in STREAM, no backpressure from the array.
module ifmap_skew_feeder
    import conv_sa_pkg::*;
#(
    parameter int PE_SIZE       = DEF_PE_SIZE,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ROW_CNT_WIDTH = DEF_ROW_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [ROW_CNT_WIDTH-1:0]      num_rows_i,
    input  logic [PE_SIZE*DATA_WIDTH-1:0] in_data_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic [PE_SIZE*DATA_WIDTH-1:0] sa_data_o,
    output logic [PE_SIZE-1:0]            sa_valid_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int DRAIN_W = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1;
    // done_o is registered, so it is armed one drain count before the last lane appears
    localparam logic [DRAIN_W-1:0] DONE_ARM = DRAIN_W'((PE_SIZE > 1) ? PE_SIZE - 2 : 0);

    sa_state_e                state;
    logic [ROW_CNT_WIDTH-1:0] num_rows_q;
    logic [ROW_CNT_WIDTH-1:0] row_cnt;
    logic [DRAIN_W-1:0]       drain_cnt;
    logic                     accept;
    logic                     last_row;

    assign accept     = (state == ST_STREAM) && in_valid_i;
    assign last_row   = accept && (row_cnt == num_rows_q - ROW_CNT_WIDTH'(1));
    assign in_ready_o = (state == ST_STREAM);
    assign busy_o     = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            num_rows_q <= '0;
            row_cnt    <= '0;
            drain_cnt  <= '0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (num_rows_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            state      <= ST_STREAM;
                            num_rows_q <= num_rows_i;
                            row_cnt    <= '0;
                        end
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        row_cnt <= row_cnt + ROW_CNT_WIDTH'(1);
                        if (last_row) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                            done_o    <= (PE_SIZE == 1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (done_o) begin
                        state <= ST_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                        done_o    <= (drain_cnt == DONE_ARM);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bubbles enter as zero data so invalid lanes never show stale values
    for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
        skew_delay_line #(
            .DEPTH      (k + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_delay (
            .clk        (clk),
            .rst        (rst),
            .push_valid (accept),
            .push_data  (accept ? in_data_i[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] : '0),
            .tap_valid  (sa_valid_o[k]),
            .tap_data   (sa_data_o[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

endmodule
